// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one DRAM request/response port between NUM_CORES requesters.
//   One transaction is in flight at a time. The winner is picked by
//   round-robin (ROUND_ROBIN=1) or by lowest index (ROUND_ROBIN=0). The
//   winner's request is latched and forwarded with its core id as the tag,
//   and the DRAM completion is routed back to that core as a one-cycle pulse.
//
// Ports
//   clk, reset_n      clock; synchronous active-low reset
//   core_req_*        per-core request vectors (addr/wdata sliced per core)
//   core_req_ready    one-hot accept pulse (combinational, IDLE cycle only)
//   core_resp_valid   one-hot completion pulse; core_resp_rdata valid with it
//   mem_req_*         latched request to DRAM, held until mem_req_ready
//   mem_resp_*        DRAM completion (reads and writes)
//   grant_id          current/last owner
//   busy              transaction in progress
//   protocol_err      sticky: DRAM response seen outside the WAIT state
module mem_bus_arbiter #(
  parameter int NUM_CORES   = 4,
  parameter int ADDR_W      = 21,
  parameter int DATA_W      = 64,
  parameter bit ROUND_ROBIN = 1'b1,
  parameter int ID_W        = $clog2(NUM_CORES)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_CORES-1:0]          core_req_valid,
  input  logic [NUM_CORES-1:0]          core_req_write,
  input  logic [NUM_CORES*ADDR_W-1:0]   core_req_addr,
  input  logic [NUM_CORES*DATA_W-1:0]   core_req_wdata,
  output logic [NUM_CORES-1:0]          core_req_ready,
  output logic [NUM_CORES-1:0]          core_resp_valid,
  output logic [DATA_W-1:0]             core_resp_rdata,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic                          mem_req_write,
  output logic [ADDR_W-1:0]             mem_req_addr,
  output logic [DATA_W-1:0]             mem_req_wdata,
  output logic [ID_W-1:0]               mem_req_tag,
  input  logic                          mem_resp_valid,
  input  logic [DATA_W-1:0]             mem_resp_rdata,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy,
  output logic                          protocol_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  localparam logic [NUM_CORES-1:0] ONE_HOT0 = {{(NUM_CORES-1){1'b0}}, 1'b1};

  state_t                state;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       scan_base;
  logic [ID_W-1:0]       winner;
  logic                  any_req;
  logic [NUM_CORES-1:0]  winner_onehot;
  logic [NUM_CORES-1:0]  owner_onehot;

  // Winner search: offsets are visited from farthest to nearest so that the
  // last match (smallest offset from scan_base) is the one that sticks.
  always_comb begin
    scan_base = ROUND_ROBIN ? rr_ptr : '0;
    any_req   = |core_req_valid;
    winner    = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      for (int unsigned j = 0; j < NUM_CORES; j++) begin
        if (core_req_valid[j] &&
            (((32'(scan_base) + (NUM_CORES - 1 - k)) % NUM_CORES) == j)) begin
          winner = ID_W'(j);
        end
      end
    end
  end

  always_comb begin
    winner_onehot  = ONE_HOT0 << winner;
    owner_onehot   = ONE_HOT0 << grant_id;
    core_req_ready = '0;
    if (reset_n && (state == IDLE) && any_req) begin
      core_req_ready = winner_onehot;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      grant_id        <= '0;
      core_resp_valid <= '0;
      core_resp_rdata <= '0;
      mem_req_valid   <= 1'b0;
      mem_req_write   <= 1'b0;
      mem_req_addr    <= '0;
      mem_req_wdata   <= '0;
      mem_req_tag     <= '0;
      busy            <= 1'b0;
      protocol_err    <= 1'b0;
    end else begin
      core_resp_valid <= '0;
      if (mem_resp_valid && (state != WAIT)) begin
        protocol_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id      <= winner;
            mem_req_tag   <= winner;
            mem_req_write <= core_req_write[winner];
            mem_req_addr  <= core_req_addr[winner*ADDR_W +: ADDR_W];
            mem_req_wdata <= core_req_wdata[winner*DATA_W +: DATA_W];
            mem_req_valid <= 1'b1;
            busy          <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            core_resp_rdata <= mem_resp_rdata;
            core_resp_valid <= owner_onehot;
            state           <= RESPOND;
          end
        end
        RESPOND: begin
          rr_ptr <= (grant_id == ID_W'(NUM_CORES - 1)) ? '0 : grant_id + 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
  localparam int N  = 4;
  localparam int AW = 21;
  localparam int DW = 64;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main (round-robin) instance
  logic            reset_n;
  logic [N-1:0]    v, wr;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    rdy, rv;
  logic [DW-1:0]   rdata;
  logic            mrv, mready, mw, mresp_v;
  logic [AW-1:0]   ma;
  logic [DW-1:0]   mwd, mresp_d;
  logic [IW-1:0]   mtag, gid;
  logic            busy, perr;

  mem_bus_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .ROUND_ROBIN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .core_req_valid(v), .core_req_write(wr), .core_req_addr(addr), .core_req_wdata(wdata),
    .core_req_ready(rdy), .core_resp_valid(rv), .core_resp_rdata(rdata),
    .mem_req_valid(mrv), .mem_req_ready(mready), .mem_req_write(mw), .mem_req_addr(ma),
    .mem_req_wdata(mwd), .mem_req_tag(mtag), .mem_resp_valid(mresp_v), .mem_resp_rdata(mresp_d),
    .grant_id(gid), .busy(busy), .protocol_err(perr));

  // fixed-priority instance
  logic            f_reset_n;
  logic [N-1:0]    f_v, f_wr;
  logic [N*AW-1:0] f_addr;
  logic [N*DW-1:0] f_wdata;
  logic [N-1:0]    f_rdy, f_rv;
  logic [DW-1:0]   f_rdata;
  logic            f_mrv, f_mready, f_mw, f_mresp_v;
  logic [AW-1:0]   f_ma;
  logic [DW-1:0]   f_mwd, f_mresp_d;
  logic [IW-1:0]   f_mtag, f_gid;
  logic            f_busy, f_perr;

  mem_bus_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .ROUND_ROBIN(1'b0)) dut_fp (
    .clk(clk), .reset_n(f_reset_n),
    .core_req_valid(f_v), .core_req_write(f_wr), .core_req_addr(f_addr), .core_req_wdata(f_wdata),
    .core_req_ready(f_rdy), .core_resp_valid(f_rv), .core_resp_rdata(f_rdata),
    .mem_req_valid(f_mrv), .mem_req_ready(f_mready), .mem_req_write(f_mw), .mem_req_addr(f_ma),
    .mem_req_wdata(f_mwd), .mem_req_tag(f_mtag), .mem_resp_valid(f_mresp_v), .mem_resp_rdata(f_mresp_d),
    .grant_id(f_gid), .busy(f_busy), .protocol_err(f_perr));

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    else n_pass++;
  endtask

  // Transaction-level reference model: one open transaction, a round-robin
  // pointer, and the events (grant, handshake, DRAM response) that move it on.
  bit            m_open, m_pend, m_wait, m_due, m_err, m_fresh;
  int            m_owner, m_rr;
  logic          m_w;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d, m_rd;

  task automatic model_reset();
    m_open = 0; m_pend = 0; m_wait = 0; m_due = 0; m_err = 0; m_fresh = 1;
    m_owner = 0; m_rr = 0; m_w = 0; m_a = '0; m_d = '0; m_rd = '0;
  endtask

  function automatic int pick_rr(input logic [N-1:0] vv, input int base);
    for (int k = 0; k < N; k++) begin
      if (vv[(base + k) % N]) return (base + k) % N;
    end
    return 0;
  endfunction

  logic [N-1:0]  smp_rdy, smp_rv;
  logic [DW-1:0] smp_rdata;
  logic          smp_mrv, smp_busy, smp_perr, smp_mw;
  logic [AW-1:0] smp_ma;
  logic [DW-1:0] smp_mwd;
  logic [IW-1:0] smp_mtag, smp_gid;

  // One clock cycle: inputs were set before the call; sample and compare at
  // the falling edge, advance the model, return 1 time unit past the rising edge.
  task automatic tick();
    logic [N-1:0] e_rdy;
    int w;
    @(negedge clk);
    smp_rdy = rdy; smp_rv = rv; smp_rdata = rdata; smp_mrv = mrv; smp_busy = busy;
    smp_perr = perr; smp_mw = mw; smp_ma = ma; smp_mwd = mwd; smp_mtag = mtag; smp_gid = gid;
    w = pick_rr(v, m_rr);
    e_rdy = (reset_n && !m_open && (v != '0)) ? (4'b0001 << w) : 4'b0000;
    chk("core_req_ready", smp_rdy, e_rdy);
    chk("mem_req_valid", smp_mrv, m_pend);
    if (m_pend || m_fresh) begin
      chk("mem_req_write", smp_mw, m_w);
      chk("mem_req_addr", smp_ma, m_a);
      chk("mem_req_wdata", smp_mwd, m_d);
      chk("mem_req_tag", smp_mtag, m_owner);
    end
    chk("core_resp_valid", smp_rv, m_due ? (4'b0001 << m_owner) : 4'b0000);
    if (m_due || m_fresh) chk("core_resp_rdata", smp_rdata, m_rd);
    chk("busy", smp_busy, m_open);
    chk("grant_id", smp_gid, m_owner);
    chk("protocol_err", smp_perr, m_err);
    if (!reset_n) model_reset();
    else begin
      if (mresp_v && !m_wait) m_err = 1;
      if (m_due) begin
        m_due = 0; m_open = 0; m_rr = (m_owner + 1) % N;
      end else if (e_rdy != '0) begin
        m_open = 1; m_pend = 1; m_owner = w; m_fresh = 0;
        m_w = wr[w]; m_a = addr[w*AW +: AW]; m_d = wdata[w*DW +: DW];
      end else if (m_pend && mready) begin
        m_pend = 0; m_wait = 1;
      end else if (m_wait && mresp_v) begin
        m_wait = 0; m_due = 1; m_rd = mresp_d;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Simple DRAM: responds resp_delay cycles after the handshake cycle + 1.
  int resp_cnt = -1;
  int resp_delay = 0;

  task automatic dram_drive();
    mresp_v = 1'b0;
    if (resp_cnt == 0) begin
      mresp_v = 1'b1; mresp_d = {$urandom, $urandom}; resp_cnt = -1;
    end else if (resp_cnt > 0) resp_cnt--;
  endtask

  task automatic dram_observe();
    if (smp_mrv && mready) resp_cnt = resp_delay;
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      dram_drive(); tick(); dram_observe();
      if (!smp_busy && !smp_mrv && resp_cnt < 0) return;
    end
    chk("drain_idle", smp_busy, 0);
  endtask

  // Random requesters: 0 idle, 1 requesting, 2 waiting for completion.
  int cst[N];

  task automatic rand_cycle(input bit allow_new);
    for (int i = 0; i < N; i++) begin
      if (cst[i] == 0 && allow_new && $urandom_range(0, 2) == 0) begin
        cst[i] = 1;
        wr[i] = 1'($urandom);
        addr[i*AW +: AW] = AW'($urandom);
        wdata[i*DW +: DW] = {$urandom, $urandom};
      end else if (cst[i] == 1 && allow_new && $urandom_range(0, 19) == 0) begin
        cst[i] = 0;
      end
      v[i] = (cst[i] == 1);
    end
    mready = 1'($urandom_range(0, 1));
    resp_delay = $urandom_range(0, 3);
    dram_drive(); tick(); dram_observe();
    for (int i = 0; i < N; i++) begin
      if (cst[i] == 1 && smp_rdy[i]) cst[i] = 2;
      else if (cst[i] == 2 && smp_rv[i]) cst[i] = 0;
    end
  endtask

  initial begin
    logic [N-1:0] gq[$];
    logic [N-1:0] exp_order[5];
    int active;
    int grants;
    bit f_hs, drop;

    reset_n = 0; v = '0; wr = '0; addr = '0; wdata = '0; mready = 0; mresp_v = 0; mresp_d = '0;
    f_reset_n = 0; f_v = '0; f_wr = '0; f_addr = '0; f_wdata = '0; f_mready = 1; f_mresp_v = 0;
    f_mresp_d = 64'h0123_4567_89AB_CDEF;
    for (int i = 0; i < N; i++) cst[i] = 0;
    @(posedge clk); #1;
    model_reset();
    tick(); tick();
    chk("reset_busy", smp_busy, 0);
    chk("reset_mem_req_valid", smp_mrv, 0);
    reset_n = 1;

    // Round-robin fairness: all cores request continuously.
    v = '1; mready = 1; resp_delay = 0;
    for (int c = 0; c < 40 && gq.size() < 5; c++) begin
      dram_drive(); tick(); dram_observe();
      if (smp_rdy != '0) gq.push_back(smp_rdy);
    end
    v = '0;
    drain();
    chk("rr_grant_count", gq.size(), 5);
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < gq.size() && i < 5; i++) chk("rr_grant_order", gq[i], exp_order[i]);

    // Single read from core 2 with immediate DRAM.
    v = 4'b0100; wr = '0; addr[2*AW +: AW] = 21'h00100; mready = 1; mresp_v = 0;
    tick(); chk("rd_ready_c0", smp_rdy, 4'b0100);
    v = '0;
    tick(); chk("rd_mvalid_c1", smp_mrv, 1); chk("rd_tag_c1", smp_mtag, 2);
    chk("rd_addr_c1", smp_ma, 21'h00100);
    mresp_v = 1; mresp_d = 64'hDEADBEEF_CAFEF00D;
    tick(); mresp_v = 0;
    tick(); chk("rd_resp_c3", smp_rv, 4'b0100); chk("rd_data_c3", smp_rdata, 64'hDEADBEEF_CAFEF00D);

    // Backpressure: DRAM not ready for 5 cycles.
    v = 4'b0010; addr[1*AW +: AW] = 21'h0ABCD; wdata[1*DW +: DW] = 64'h1234_5678_9ABC_DEF0; mready = 0;
    tick(); chk("bp_ready", smp_rdy, 4'b0010);
    v = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_mvalid_hold", smp_mrv, 1); chk("bp_addr_hold", smp_ma, 21'h0ABCD);
      chk("bp_wdata_hold", smp_mwd, 64'h1234_5678_9ABC_DEF0); chk("bp_tag_hold", smp_mtag, 1);
    end
    mready = 1;
    tick(); chk("bp_handshake", smp_mrv, 1);
    mready = 0; mresp_v = 1; mresp_d = 64'h0F0F;
    tick(); chk("bp_mvalid_drop", smp_mrv, 0);
    mresp_v = 0;
    tick(); chk("bp_resp", smp_rv, 4'b0010);

    // Write from core 0 to the top address, 3-cycle DRAM delay.
    v = 4'b0001; wr = 4'b0001; addr[0 +: AW] = 21'h1FFFFF; wdata[0 +: DW] = 64'h55; mready = 1;
    tick(); chk("wr_ready", smp_rdy, 4'b0001);
    v = '0; wr = '0;
    tick(); chk("wr_write", smp_mw, 1); chk("wr_addr", smp_ma, 21'h1FFFFF); chk("wr_wdata", smp_mwd, 64'h55);
    tick(); tick(); tick();
    chk("wr_no_early_resp", smp_rv, 0);
    mresp_v = 1; mresp_d = 64'hAAAA;
    tick(); mresp_v = 0;
    tick(); chk("wr_resp", smp_rv, 4'b0001);

    // Randomized traffic, then drain without new requests.
    for (int c = 0; c < 3000; c++) rand_cycle(1'b1);
    for (int c = 0; c < 300; c++) begin
      active = 0;
      for (int i = 0; i < N; i++) if (cst[i] != 0) active++;
      if (active == 0 && !smp_busy && resp_cnt < 0) break;
      rand_cycle(1'b0);
    end
    active = 0;
    for (int i = 0; i < N; i++) if (cst[i] != 0) active++;
    chk("rand_clients_done", active, 0);
    v = '0; wr = '0; mresp_v = 0;

    // Reset in WAIT, then a stale DRAM response.
    v = 4'b1000; mready = 1;
    tick(); v = '0;
    tick();
    reset_n = 0;
    tick(); tick();
    chk("rst_busy", smp_busy, 0); chk("rst_mvalid", smp_mrv, 0);
    chk("rst_gid", smp_gid, 0); chk("rst_resp", smp_rv, 0); chk("rst_perr", smp_perr, 0);
    reset_n = 1; mresp_v = 1;
    tick(); mresp_v = 0;
    tick(); chk("stale_perr", smp_perr, 1); chk("stale_no_resp", smp_rv, 0);
    tick(); chk("stale_no_resp2", smp_rv, 0);

    // Fixed priority: cores 1 and 3 request; core 1 drops after three grants.
    f_reset_n = 0; @(posedge clk); #1; f_reset_n = 1;
    f_v = 4'b1010; f_hs = 0; grants = 0; drop = 0;
    for (int c = 0; c < 60 && grants < 4; c++) begin
      f_mresp_v = f_hs;
      @(negedge clk);
      f_hs = f_mrv;
      if (f_rdy != '0) begin
        chk("fp_grant", f_rdy, (grants < 3) ? 4'b0010 : 4'b1000);
        grants++;
        if (grants == 3) drop = 1;
      end
      @(posedge clk); #1;
      if (drop) f_v[1] = 1'b0;
    end
    chk("fp_grant_count", grants, 4);
    chk("fp_perr", f_perr, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Parametrised N-core arbiter sharing one DRAM memory bus. It lets several fetch/vector-memory clients, one per core_id, share a single DRAM port in multi-core builds. It accepts one request at a time from NUM_CORES requesters using round-robin or fixed-priority selection, and forwards it to DRAM tagged with the owner id. It routes the DRAM response back to the owning core. It replaces the direct one-core-to-DRAM connection.

## Interface
- NUM_CORES, 4: number of requesting cores (≥2).
- ADDR_W, 21: physical address width (matches phys_memory_address_t).
- DATA_W, 64: request/response data width.
- ROUND_ROBIN, 1: 1 = round-robin, 0 = fixed priority (lowest index wins).
- ID_W, $clog2(NUM_CORES): owner tag width (derived).

Ports:
- clk  in  1  clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- core_req_valid  in  NUM_CORES  per-core request pending.
- core_req_write  in  NUM_CORES  per-core 1 = write, 0 = read.
- core_req_addr  in  NUM_CORES*ADDR_W  per-core address; core i occupies bits [i*ADDR_W +: ADDR_W].
- core_req_wdata  in  NUM_CORES*DATA_W  per-core write data; same slicing as core_req_addr.
- core_req_ready  out  NUM_CORES  one-hot accept pulse.
- core_resp_valid  out  NUM_CORES  one-hot completion pulse.
- core_resp_rdata  out  DATA_W  shared read data; valid with core_resp_valid.
- mem_req_valid  out  1  request to DRAM.
- mem_req_ready  in  1  DRAM accepts.
- mem_req_write, mem_req_addr, mem_req_wdata  out  1/ADDR_W/DATA_W  latched request.
- mem_req_tag  out  ID_W  owner core id.
- mem_resp_valid  in  1  DRAM completion; reads and writes both complete this way.
- mem_resp_rdata  in  DATA_W  read data.
- grant_id  out  ID_W  current owner.
- busy  out  1  state ≠ IDLE.
- protocol_err  out  1  sticky error flag.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESPOND. At most one outstanding transaction.
- IDLE, no core_req_valid bit set: stay in IDLE.
- IDLE, any core_req_valid bit set:
  - Select winner W by the active policy.
  - Pulse core_req_ready[W] for that cycle.
  - Latch write/addr/wdata of core W; grant_id ← W.
  - Go to ISSUE.
- Round-robin selection: scan from rr_ptr upward, wrapping modulo NUM_CORES; first set bit wins.
- Fixed-priority selection: lowest set index wins; rr_ptr is unused.
- ISSUE: hold mem_req_valid = 1 with latched fields stable until mem_req_ready = 1, then go to WAIT.
- WAIT: on mem_resp_valid, latch mem_resp_rdata (reads; writes latch it too, value don't-care) and go to RESPOND.
- RESPOND, one cycle:
  - core_resp_valid[grant_id] = 1 and core_resp_rdata driven.
  - rr_ptr ← (W == NUM_CORES-1) ? 0 : W+1.
  - Go to IDLE.
- Requester obligations:
  - Hold valid and fields stable until it sees its ready pulse.
  - Must not issue a new request until it has seen its resp_valid.
  - Core i may deassert valid before being granted; it is then simply not selected.
- protocol_err is set (sticky until reset) when mem_resp_valid arrives in any state other than WAIT. Such a response is otherwise ignored.
- Reset values: state IDLE; rr_ptr 0; grant_id 0; all outputs 0 (valid/ready/resp vectors, mem_req_* fields, rdata, busy, protocol_err).
- Reset asserted mid-transaction: the pending transaction is dropped and there is no core_resp_valid. A DRAM response arriving after reset release is flagged as protocol_err.

## Timing
- Outputs are registered, except core_req_ready, which is a pulse in the IDLE grant cycle.
- Latency with request at cycle 0 and DRAM ready and response immediate:
  - Accept at cycle 0.
  - mem_req_valid at cycle 1; handshake at cycle 1.
  - WAIT at cycle 2; mem_resp_valid at cycle 2.
  - core_resp_valid at cycle 3.
- General latency: core_resp_valid arrives one cycle after mem_resp_valid.
- Throughput: at most one transaction per 4 cycles.
- Back-to-back: a new grant is possible in the cycle after RESPOND.
- Simultaneous requests from all cores: exactly one ready bit per grant cycle; no core waits more than NUM_CORES-1 grants under round-robin.
- mem_req_valid must not drop while mem_req_ready = 0.

## Test plan
- Single read: core 2 reads addr 0x00100, DRAM returns 0xDEADBEEF_CAFEF00D with 0-cycle latency -> core_req_ready = 4'b0100 at cycle 0, mem_req_tag = 2 at cycle 1, core_resp_valid = 4'b0100 with that data at cycle 3.
- Round-robin fairness: all 4 cores request continuously -> grant order 0,1,2,3,0; rr_ptr wraps 3 -> 0.
- Fixed priority (ROUND_ROBIN = 0): cores 1 and 3 request continuously -> core 1 granted every time; core 3 is granted only once core 1 deasserts.
- DRAM backpressure: mem_req_ready low for 5 cycles -> mem_req_valid/addr/wdata/tag stay stable for all 5 cycles, then one handshake.
- Write with 3-cycle response delay: core 0 writes 0x55 to 0x1FFFFF -> mem_req_write = 1 at the full-width address; core_resp_valid[0] fires 1 cycle after mem_resp_valid.
- Reset and spurious response: reset_n low while in WAIT -> all outputs 0, state IDLE; a mem_resp_valid after release -> protocol_err = 1 and no core_resp_valid.
